multi_channel_clock_divider: RTL and testbench

- Parametrised successor to the fixed single-output slow clock divider.
- Provides NCH independent divider channels from one input clock.
- Each channel has a runtime-loadable divisor, an enable, a synchronous clear, a square-wave output and a one-cycle tick output.
- Used by the game logic for game timers, display refresh and debounce strobes, all derived from the 50 MHz board clock.

---
 rtl/multi_channel_clock_divider.sv | 148 ++++++++++++++
 tb/tb_multi_channel_clock_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_clock_divider
// Description : NCH independent divider channels clocked from cin. Each
//               channel has a runtime-loadable divisor, an enable, a
//               synchronous clear, a registered square-wave output (cout)
//               and a registered one-cycle terminal-count pulse (tick).
//               A newly loaded divisor is held in a pending register and
//               takes over at the next wrap, at a clear, or immediately
//               while the channel is disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_clock_divider #(
  parameter int          NCH         = 2,
  parameter int          W           = 32,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic             cin,
  input  logic             resetn,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   clr,
  input  logic [NCH-1:0]   load,
  input  logic [NCH*W-1:0] div_in,
  output logic [NCH-1:0]   cout,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pend
);

  // Reset divisor, forced to at least 1 so the terminal compare never
  // underflows even if the parameter is misconfigured.
  localparam logic [W-1:0] c_default_raw = W'(DEFAULT_DIV);
  localparam logic [W-1:0] c_default_div =
    (c_default_raw == '0) ? W'(1) : c_default_raw;

  genvar g;
  generate
    for (g = 0; g < NCH; g = g + 1) begin : g_ch
      // Registered channel state
      logic [W-1:0] count_q;
      logic [W-1:0] act_div_q;
      logic [W-1:0] pend_div_q;
      logic         pend_q;
      logic         cout_q;
      logic         tick_q;

      // Next-state values
      logic [W-1:0] count_d;
      logic [W-1:0] act_div_d;
      logic [W-1:0] pend_div_d;
      logic         pend_d;
      logic         cout_d;
      logic         tick_d;

      // Divisor slice for this channel and its sanitised form (0 -> 1)
      logic [W-1:0] div_raw;
      logic [W-1:0] div_san;
      logic         terminal;

      assign div_raw = div_in[g*W +: W];
      assign div_san = (div_raw == '0) ? W'(1) : div_raw;

      // ">=" rather than "==" so a count already beyond a freshly shrunk
      // divisor still wraps on the next enabled edge instead of running
      // on towards 2^W-1. act_div_q is never 0, so the subtract is safe.
      assign terminal = en[g] && (count_q >= (act_div_q - W'(1)));

      // Next-state selection: clear, then terminal wrap, then count/hold
      always_comb begin
        count_d    = count_q;
        act_div_d  = act_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        cout_d     = cout_q;
        tick_d     = 1'b0;

        if (clr[g]) begin
          // Clear restarts the period; any divisor change lands now.
          count_d = '0;
          cout_d  = 1'b0;
          if (load[g]) begin
            act_div_d  = div_san;
            pend_div_d = div_san;
            pend_d     = 1'b0;
          end else if (pend_q) begin
            act_div_d = pend_div_q;
            pend_d    = 1'b0;
          end
        end else if (terminal) begin
          // Wrap: toggle the square wave, pulse tick, adopt new divisor.
          count_d = '0;
          cout_d  = ~cout_q;
          tick_d  = 1'b1;
          if (load[g]) begin
            act_div_d  = div_san;
            pend_div_d = div_san;
            pend_d     = 1'b0;
          end else if (pend_q) begin
            act_div_d = pend_div_q;
            pend_d    = 1'b0;
          end
        end else if (en[g]) begin
          // Mid-period: keep counting, park any new divisor until the wrap.
          count_d = count_q + W'(1);
          if (load[g]) begin
            pend_div_d = div_san;
            pend_d     = 1'b1;
          end
        end else begin
          // Disabled: count and cout hold. A parked divisor is applied
          // straight away; a load this cycle is applied on the next one.
          if (load[g]) begin
            pend_div_d = div_san;
            pend_d     = 1'b1;
          end else if (pend_q) begin
            act_div_d = pend_div_q;
            pend_d    = 1'b0;
          end
        end
      end

      // State register with synchronous active-low reset
      always_ff @(posedge cin) begin
        if (!resetn) begin
          count_q    <= '0;
          act_div_q  <= c_default_div;
          pend_div_q <= c_default_div;
          pend_q     <= 1'b0;
          cout_q     <= 1'b0;
          tick_q     <= 1'b0;
        end else begin
          count_q    <= count_d;
          act_div_q  <= act_div_d;
          pend_div_q <= pend_div_d;
          pend_q     <= pend_d;
          cout_q     <= cout_d;
          tick_q     <= tick_d;
        end
      end

      // Outputs come straight from flops; no input-to-output path.
      assign cout[g] = cout_q;
      assign tick[g] = tick_q;
      assign pend[g] = pend_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_clock_divider
// Description : Directed bench for multi_channel_clock_divider with NCH=2,
//               W=8, DEFAULT_DIV=4. A per-cycle vector table covers the
//               basic divide and a pending load; short hand-written
//               sequences cover the multi-cycle corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_clock_divider;

  logic        cin;
  logic        resetn;
  logic [1:0]  en;
  logic [1:0]  clr;
  logic [1:0]  load;
  logic [15:0] div_in;
  logic [1:0]  cout;
  logic [1:0]  tick;
  logic [1:0]  pend;

  int n_checks;
  int n_fail;

  multi_channel_clock_divider #(
    .NCH         (2),
    .W           (8),
    .DEFAULT_DIV (4)
  ) dut (
    .cin    (cin),
    .resetn (resetn),
    .en     (en),
    .clr    (clr),
    .load   (load),
    .div_in (div_in),
    .cout   (cout),
    .tick   (tick),
    .pend   (pend)
  );

  initial cin = 1'b0;
  always #5 cin = ~cin;

  typedef struct {
    logic [1:0] en;
    logic [1:0] clr;
    logic [1:0] load;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] tick;
    logic [1:0] cout;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl [12];

  // Drive inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic rn, input logic [1:0] e, input logic [1:0] c,
                      input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1);
    @(negedge cin);
    resetn = rn;
    en     = e;
    clr    = c;
    load   = l;
    div_in = {d1, d0};
    @(posedge cin);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    step(1'b0, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
    check("reset tick", tick, 2'b00);
    check("reset cout", cout, 2'b00);
    check("reset pend", pend, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    en       = 2'b00;
    clr      = 2'b00;
    load     = 2'b00;
    div_in   = '0;

    // Cycle k (1-based) = k-th enabled edge after reset. Bits are {ch1,ch0}.
    // ch1 runs the default divisor 4; ch0 loads 3 at cycle 2, applied at the
    // wrap on cycle 4, then ticks on 7 and 10.
    //            en     clr    load   d0    d1    tick   cout   pend
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b11, 2'b00, 2'b01, 8'd3, 8'd0, 2'b00, 2'b00, 2'b01};
    tbl[2]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b00};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b10, 2'b00};
    tbl[7]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b00, 2'b00};
    tbl[8]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b01, 2'b01, 2'b00};
    tbl[10] = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 2'b00};
    tbl[11] = '{2'b11, 2'b00, 2'b00, 8'd0, 8'd0, 2'b10, 2'b11, 2'b00};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].d0, tbl[i].d1);
      check($sformatf("tbl c%0d tick", i + 1), tick, tbl[i].tick);
      check($sformatf("tbl c%0d cout", i + 1), cout, tbl[i].cout);
      check($sformatf("tbl c%0d pend", i + 1), pend, tbl[i].pend);
    end

    // Divisor 0 (sanitised to 1) and divisor 1 on ch1: continuous tick after
    // the wrap on cycle 4, cout toggling every cycle. ch0 stays at 4.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      step(1'b1, 2'b11, 2'b00, 2'b10, 8'd0, 8'(v));
      check($sformatf("d%0d pend1 c1", v), 2'(pend[1]), 2'b01);
      for (int k = 2; k <= 8; k++) begin
        step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
        check($sformatf("d%0d tick0 c%0d", v, k), 2'(tick[0]), 2'((k % 4) == 0));
        if (k >= 4) begin
          check($sformatf("d%0d tick1 c%0d", v, k), 2'(tick[1]), 2'b01);
          check($sformatf("d%0d cout1 c%0d", v, k), 2'(cout[1]), 2'((k % 2) == 0));
          check($sformatf("d%0d pend1 c%0d", v, k), 2'(pend[1]), 2'b00);
        end else begin
          check($sformatf("d%0d tick1 c%0d", v, k), 2'(tick[1]), 2'b00);
        end
      end
    end

    // ch0 paused for 5 cycles at count=2 with cout=1: everything holds,
    // then the next tick comes on the second re-enabled edge.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("pause tick0 c%0d", k), 2'(tick[0]), 2'(k == 4));
    end
    for (int k = 7; k <= 11; k++) begin
      step(1'b1, 2'b10, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("pause held tick0 c%0d", k), 2'(tick[0]), 2'b00);
      check($sformatf("pause held cout0 c%0d", k), 2'(cout[0]), 2'b01);
      check($sformatf("pause tick1 c%0d", k), 2'(tick[1]), 2'((k % 4) == 0));
    end
    step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
    check("pause resume tick0 c12", 2'(tick[0]), 2'b00);
    check("pause tick1 c12", 2'(tick[1]), 2'b01);
    step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
    check("pause resume tick0 c13", 2'(tick[0]), 2'b01);
    check("pause resume cout0 c13", 2'(cout[0]), 2'b00);

    // clr and load 2 together on ch0 at count=3 with cout=1 (cycle 8): clear
    // beats the wrap; afterwards ticks every 2 cycles. ch1 keeps its rhythm.
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("clr pre tick0 c%0d", k), 2'(tick[0]), 2'(k == 4));
    end
    step(1'b1, 2'b11, 2'b01, 2'b01, 8'd2, 8'd0);
    check("clr tick0 c8", 2'(tick[0]), 2'b00);
    check("clr cout0 c8", 2'(cout[0]), 2'b00);
    check("clr pend0 c8", 2'(pend[0]), 2'b00);
    check("clr tick1 c8", 2'(tick[1]), 2'b01);
    for (int k = 9; k <= 14; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("clr tick0 c%0d", k), 2'(tick[0]), 2'(((k - 8) % 2) == 0));
      check($sformatf("clr cout0 c%0d", k), 2'(cout[0]), 2'(((k - 8) / 2) % 2));
      check($sformatf("clr tick1 c%0d", k), 2'(tick[1]), 2'((k % 4) == 0));
    end

    // Reset while a load of 7 is pending: the pending divisor is dropped
    // and ch0 returns to the default period of 4.
    do_reset();
    step(1'b1, 2'b11, 2'b00, 2'b01, 8'd7, 8'd0);
    check("rst pend0 c1", 2'(pend[0]), 2'b01);
    step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
    check("rst pend0 c2", 2'(pend[0]), 2'b01);
    step(1'b0, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
    check("rst mid pend", pend, 2'b00);
    check("rst mid tick", tick, 2'b00);
    check("rst mid cout", cout, 2'b00);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("rst after tick0 c%0d", k), 2'(tick[0]), 2'((k % 4) == 0));
      check($sformatf("rst after pend0 c%0d", k), 2'(pend[0]), 2'b00);
    end

    // ch1 disabled: a load of 2 is pending for exactly one cycle. ch0
    // enabled: loads of 6 then 2 before the wrap; the last one wins.
    do_reset();
    step(1'b1, 2'b01, 2'b00, 2'b11, 8'd6, 8'd2);
    check("lw pend c1", pend, 2'b11);
    step(1'b1, 2'b01, 2'b00, 2'b01, 8'd2, 8'd0);
    check("lw pend c2", pend, 2'b01);
    check("lw tick c2", tick, 2'b00);
    for (int k = 3; k <= 8; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("lw tick c%0d", k), tick, ((k % 2) == 0) ? 2'b11 : 2'b00);
      check($sformatf("lw pend c%0d", k), pend, (k == 3) ? 2'b01 : 2'b00);
    end

    // Load of 3 on ch0 coinciding with its wrap at cycle 4: applied at once,
    // pend never rises, next ticks on 7 and 10.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
    end
    step(1'b1, 2'b11, 2'b00, 2'b01, 8'd3, 8'd0);
    check("wrapload pend0 c4", 2'(pend[0]), 2'b00);
    check("wrapload tick0 c4", 2'(tick[0]), 2'b01);
    for (int k = 5; k <= 10; k++) begin
      step(1'b1, 2'b11, 2'b00, 2'b00, 8'd0, 8'd0);
      check($sformatf("wrapload tick0 c%0d", k), 2'(tick[0]), 2'((k == 7) || (k == 10)));
      check($sformatf("wrapload pend0 c%0d", k), 2'(pend[0]), 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
